// File: rtl/credit_arbiter.sv
// Credit accumulator arbiter: coin inserts, purchases and greedy change refund
// share one 7-bit credit register, granted at most one request per cycle.
module credit_arbiter #(
   parameter int CREDIT_MAX = 79,
   parameter int COIN0_VAL  = 1,
   parameter int COIN1_VAL  = 5,
   parameter int COIN2_VAL  = 10,
   parameter int COIN3_VAL  = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] coin_sw,
   input  logic       buy_req,
   input  logic [3:0] buy_price,
   input  logic       refund_req,
   output logic [6:0] credit,
   output logic       buy_ack,
   output logic       buy_nack,
   output logic       coin_reject,
   output logic       chg_valid,
   output logic [1:0] chg_coin,
   output logic       refund_done,
   output logic       busy
);

   localparam logic IDLE   = 1'b0;
   localparam logic REFUND = 1'b1;

   localparam logic [7:0] MAX = 8'(CREDIT_MAX);
   localparam logic [7:0] V0  = 8'(COIN0_VAL);
   localparam logic [7:0] V1  = 8'(COIN1_VAL);
   localparam logic [7:0] V2  = 8'(COIN2_VAL);
   localparam logic [7:0] V3  = 8'(COIN3_VAL);

   logic       state, state_nxt;
   logic [3:0] sw_q, pend, rise, csel, clr;
   logic [7:0] cr, cr_nxt, cval, chg_val;
   logic [1:0] chg_idx;
   logic       ack_nxt, nack_nxt, rej_nxt, cv_nxt, done_nxt;

   assign cr   = {1'b0, credit};
   assign rise = coin_sw & ~sw_q;
   assign busy = (state == REFUND);

   // lowest-index pending coin wins
   always_comb begin
      csel = 4'b0000;
      cval = V0;
      if (pend[0]) begin
         csel = 4'b0001;
         cval = V0;
      end else if (pend[1]) begin
         csel = 4'b0010;
         cval = V1;
      end else if (pend[2]) begin
         csel = 4'b0100;
         cval = V2;
      end else if (pend[3]) begin
         csel = 4'b1000;
         cval = V3;
      end
   end

   // greedy change: largest coin not above the remaining credit
   always_comb begin
      chg_idx = 2'd0;
      chg_val = V0;
      if (cr >= V3) begin
         chg_idx = 2'd3;
         chg_val = V3;
      end else if (cr >= V2) begin
         chg_idx = 2'd2;
         chg_val = V2;
      end else if (cr >= V1) begin
         chg_idx = 2'd1;
         chg_val = V1;
      end
   end

   always_comb begin
      state_nxt = state;
      cr_nxt    = cr;
      clr       = 4'b0000;
      ack_nxt   = 1'b0;
      nack_nxt  = 1'b0;
      rej_nxt   = 1'b0;
      cv_nxt    = 1'b0;
      done_nxt  = 1'b0;
      if (state == IDLE) begin
         if (refund_req) begin
            nack_nxt = buy_req;
            if (cr == 8'd0) done_nxt = 1'b1;
            else state_nxt = REFUND;
         end else if (buy_req) begin
            if (cr >= {4'b0000, buy_price}) begin
               cr_nxt  = cr - {4'b0000, buy_price};
               ack_nxt = 1'b1;
            end else begin
               nack_nxt = 1'b1;
            end
         end else if (|pend) begin
            clr = csel;
            if (cr + cval <= MAX) cr_nxt = cr + cval;
            else rej_nxt = 1'b1;
         end
      end else begin
         nack_nxt = buy_req;
         if (cr == 8'd0) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end else begin
            cv_nxt = 1'b1;
            cr_nxt = cr - chg_val;
            if (cr == chg_val) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         sw_q        <= 4'b0000;
         pend        <= 4'b0000;
         credit      <= 7'd0;
         buy_ack     <= 1'b0;
         buy_nack    <= 1'b0;
         coin_reject <= 1'b0;
         chg_valid   <= 1'b0;
         chg_coin    <= 2'd0;
         refund_done <= 1'b0;
      end else begin
         state       <= state_nxt;
         sw_q        <= coin_sw;
         pend        <= (pend & ~clr) | rise;
         credit      <= 7'(cr_nxt);
         buy_ack     <= ack_nxt;
         buy_nack    <= nack_nxt;
         coin_reject <= rej_nxt;
         chg_valid   <= cv_nxt;
         chg_coin    <= cv_nxt ? chg_idx : 2'd0;
         refund_done <= done_nxt;
      end
   end

endmodule

// File: tb/tb_credit_arbiter.sv
// Directed bench for credit_arbiter: coins, saturation, buys, refunds
// and reset during a refund, checked with immediate assertions.
module tb_credit_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] coin_sw;
   logic       buy_req;
   logic [3:0] buy_price;
   logic       refund_req;
   logic [6:0] credit;
   logic       buy_ack;
   logic       buy_nack;
   logic       coin_reject;
   logic       chg_valid;
   logic [1:0] chg_coin;
   logic       refund_done;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   credit_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .coin_sw     (coin_sw),
      .buy_req     (buy_req),
      .buy_price   (buy_price),
      .refund_req  (refund_req),
      .credit      (credit),
      .buy_ack     (buy_ack),
      .buy_nack    (buy_nack),
      .coin_reject (coin_reject),
      .chg_valid   (chg_valid),
      .chg_coin    (chg_coin),
      .refund_done (refund_done),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic coin(input int i, input int exp_cr, input logic exp_rej);
      coin_sw[i] = 1'b1;
      tick;
      coin_sw[i] = 1'b0;
      tick;
      chk("coin_credit", 32'(credit), exp_cr);
      chk("coin_reject", 32'(coin_reject), 32'(exp_rej));
   endtask

   task automatic buy(input int p, input int exp_cr, input logic exp_ack);
      buy_req   = 1'b1;
      buy_price = 4'(p);
      tick;
      buy_req = 1'b0;
      chk("buy_credit", 32'(credit), exp_cr);
      chk("buy_ack", 32'(buy_ack), 32'(exp_ack));
      chk("buy_nack", 32'(buy_nack), 32'(!exp_ack));
   endtask

   task automatic chg(input int idx, input int exp_cr, input logic exp_done,
                      input logic exp_busy);
      tick;
      chk("chg_valid", 32'(chg_valid), 1);
      chk("chg_coin", 32'(chg_coin), idx);
      chk("chg_credit", 32'(credit), exp_cr);
      chk("chg_done", 32'(refund_done), 32'(exp_done));
      chk("chg_busy", 32'(busy), 32'(exp_busy));
   endtask

   initial begin
      rst        = 1'b0;
      coin_sw    = 4'b0000;
      buy_req    = 1'b0;
      buy_price  = 4'd0;
      refund_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_credit", 32'(credit), 0);
      chk("rst_ack", 32'(buy_ack), 0);
      chk("rst_nack", 32'(buy_nack), 0);
      chk("rst_reject", 32'(coin_reject), 0);
      chk("rst_chg", 32'(chg_valid), 0);
      chk("rst_coin", 32'(chg_coin), 0);
      chk("rst_done", 32'(refund_done), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b1;
      tick;

      // three 20-coins
      coin(3, 20, 1'b0);
      coin(3, 40, 1'b0);
      coin(3, 60, 1'b0);

      // simultaneous edges: 1 first, then 20 overflows 79
      coin_sw = 4'b1001;
      tick;
      coin_sw = 4'b0000;
      tick;
      chk("dual_first", 32'(credit), 61);
      chk("dual_first_rej", 32'(coin_reject), 0);
      tick;
      chk("dual_second", 32'(credit), 61);
      chk("dual_second_rej", 32'(coin_reject), 1);
      tick;
      chk("rej_pulse_end", 32'(coin_reject), 0);
      coin(2, 71, 1'b0);
      coin(1, 76, 1'b0);
      coin(0, 77, 1'b0);
      coin(0, 78, 1'b0);
      coin(0, 79, 1'b0);
      coin(0, 79, 1'b1);

      // purchases down to 7, then boundary prices
      buy(15, 64, 1'b1);
      buy(15, 49, 1'b1);
      buy(15, 34, 1'b1);
      buy(15, 19, 1'b1);
      buy(12, 7, 1'b1);
      buy(8, 7, 1'b0);
      buy(7, 0, 1'b1);
      buy(0, 0, 1'b1);

      // refund with zero credit
      refund_req = 1'b1;
      tick;
      refund_req = 1'b0;
      chk("zref_done", 32'(refund_done), 1);
      chk("zref_busy", 32'(busy), 0);
      chk("zref_chg", 32'(chg_valid), 0);
      tick;
      chk("zref_done_end", 32'(refund_done), 0);

      // refund of 36
      coin(3, 20, 1'b0);
      coin(2, 30, 1'b0);
      coin(1, 35, 1'b0);
      coin(0, 36, 1'b0);
      refund_req = 1'b1;
      tick;
      refund_req = 1'b0;
      chk("ref_busy", 32'(busy), 1);
      chk("ref_idle_chg", 32'(chg_valid), 0);
      chk("ref_credit", 32'(credit), 36);
      chg(3, 16, 1'b0, 1'b1);
      chg(2, 6, 1'b0, 1'b1);
      chg(1, 1, 1'b0, 1'b1);
      chg(0, 0, 1'b1, 1'b0);
      tick;
      chk("ref_after_chg", 32'(chg_valid), 0);
      chk("ref_after_done", 32'(refund_done), 0);

      // refund beats buy; coin edge during refund waits
      coin(2, 10, 1'b0);
      refund_req = 1'b1;
      buy_req    = 1'b1;
      buy_price  = 4'd1;
      tick;
      refund_req = 1'b0;
      buy_req    = 1'b0;
      coin_sw[1] = 1'b1;
      chk("rb_nack", 32'(buy_nack), 1);
      chk("rb_ack", 32'(buy_ack), 0);
      chk("rb_busy", 32'(busy), 1);
      chk("rb_credit", 32'(credit), 10);
      chg(2, 0, 1'b1, 1'b0);
      coin_sw[1] = 1'b0;
      tick;
      chk("rb_coin_late", 32'(credit), 5);

      // reset in the middle of a refund
      coin(3, 25, 1'b0);
      coin(2, 35, 1'b0);
      coin(0, 36, 1'b0);
      refund_req = 1'b1;
      tick;
      refund_req = 1'b0;
      chg(3, 16, 1'b0, 1'b1);
      chg(2, 6, 1'b0, 1'b1);
      rst = 1'b0;
      #1;
      chk("mrst_credit", 32'(credit), 0);
      chk("mrst_chg", 32'(chg_valid), 0);
      chk("mrst_coin", 32'(chg_coin), 0);
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_done", 32'(refund_done), 0);
      tick;
      tick;
      chk("mrst_done_hold", 32'(refund_done), 0);
      rst = 1'b1;
      tick;
      chk("mrst_idle", 32'(busy), 0);
      chk("mrst_no_done", 32'(refund_done), 0);
      coin(0, 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
